// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
//   lsu_funct3_e : RV32I load/store width encodings
//   lsu_state_e  : controller FSM states
//   funct3_legal : funct3 legality for a load (we=0) or store (we=1)
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR_RESP
    } lsu_state_e;

    // Unsigned variants only exist for loads.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   funct3_i  : access width / signedness
//   addr_lo_i : byte offset within the word
//   word_i    : word read from memory
//   wdata_i   : right-aligned store data
//   ld_data_o : extracted and extended load value
//   st_data_o : word to write back (merged for SB/SH, wdata_i for SW)
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned REG_SIZE = 32
) (
    input  logic [2:0]          funct3_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [REG_SIZE-1:0] word_i,
    input  logic [REG_SIZE-1:0] wdata_i,
    output logic [REG_SIZE-1:0] ld_data_o,
    output logic [REG_SIZE-1:0] st_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        // Half select uses addr[1] only, so a misaligned half truncates.
        half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];

        case (funct3_i)
            F3_B:    ld_data_o = {{(REG_SIZE-8){byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data_o = {{(REG_SIZE-8){1'b0}}, byte_sel};
            F3_H:    ld_data_o = {{(REG_SIZE-16){half_sel[15]}}, half_sel};
            F3_HU:   ld_data_o = {{(REG_SIZE-16){1'b0}}, half_sel};
            default: ld_data_o = word_i;
        endcase

        st_data_o = word_i;
        case (funct3_i[1:0])
            2'b00:   st_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            2'b01:   st_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: st_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one byte/half/word request at a time into word-aligned
// memory accesses. Sub-word stores are read-modify-write.
//   req_*  : valid/ready request from the execute stage
//   rsp_*  : one-cycle response pulse with registered load data / error flag
//   mem_*  : master side of the word-wide data memory (combinational read)
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses produce an
// error response instead of being truncated to the containing half/word.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned REG_SIZE = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [2:0]          req_funct3_i,
    input  logic [REG_SIZE-1:0] req_addr_i,
    input  logic [REG_SIZE-1:0] req_wdata_i,
    output logic                rsp_valid_o,
    output logic [REG_SIZE-1:0] rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                mem_we_o,
    output logic [REG_SIZE-1:0] mem_addr_o,
    output logic [REG_SIZE-1:0] mem_wdata_o,
    input  logic [REG_SIZE-1:0] mem_rdata_i
);

    lsu_state_e          state_q;
    logic                op_we_q;
    logic [2:0]          op_funct3_q;
    logic [1:0]          op_addr_lo_q;
    logic [REG_SIZE-1:0] op_wdata_q;
    logic [REG_SIZE-1:0] rdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [REG_SIZE-1:0] rsp_rdata_q;
    logic                mem_we_q;
    logic [REG_SIZE-1:0] mem_addr_q;
    logic [REG_SIZE-1:0] mem_wdata_q;

    logic [REG_SIZE-1:0] req_word_addr;
    logic [REG_SIZE-1:0] ld_data;
    logic [REG_SIZE-1:0] st_data;
    logic                req_illegal;

    assign req_word_addr = {req_addr_i[REG_SIZE-1:2], 2'b00};

    always_comb begin
        req_illegal = !funct3_legal(req_we_i, req_funct3_i);
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3_i)
            F3_H, F3_HU: if (req_addr_i[0]) req_illegal = 1'b1;
            F3_W:        if (req_addr_i[1:0] != 2'b00) req_illegal = 1'b1;
            default:     ;
        endcase
`endif
    end

    lsu_align #(
        .REG_SIZE (REG_SIZE)
    ) u_align (
        .funct3_i  (op_funct3_q),
        .addr_lo_i (op_addr_lo_q),
        .word_i    (mem_rdata_i),
        .wdata_i   (op_wdata_q),
        .ld_data_o (ld_data),
        .st_data_o (st_data)
    );

    // Response outputs are registered on the edge leaving RESP/ERR_RESP, so they
    // appear together with the return to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            op_we_q      <= 1'b0;
            op_funct3_q  <= 3'b000;
            op_addr_lo_q <= 2'b00;
            op_wdata_q   <= '0;
            rdata_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_we_q      <= req_we_i;
                        op_funct3_q  <= req_funct3_i;
                        op_addr_lo_q <= req_addr_i[1:0];
                        op_wdata_q   <= req_wdata_i;
                        if (req_illegal) begin
                            state_q <= ERR_RESP;
                        end else if (req_we_i && req_funct3_i == F3_W) begin
                            // Full-word store needs no read.
                            state_q     <= WRITE;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= req_word_addr;
                            mem_wdata_q <= req_wdata_i;
                        end else begin
                            state_q    <= READ;
                            mem_addr_q <= req_word_addr;
                        end
                    end
                end
                READ: begin
                    rdata_q <= ld_data;
                    if (op_we_q) begin
                        state_q     <= WRITE;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= st_data;
                    end else begin
                        state_q    <= RESP;
                        mem_addr_q <= '0;
                    end
                end
                WRITE: begin
                    state_q    <= RESP;
                    mem_addr_q <= '0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= op_we_q ? '0 : rdata_q;
                end
                ERR_RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    // Gated so a write can never coincide with an asserted reset.
    assign mem_we_o    = mem_we_q & rst_ni;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
